// File: rtl/dma_dev_endpoint.sv
// Device-side endpoint of the DMA device handshake.
// Issues one request per host command, then feeds (write) or captures (read)
// words through a local 2^BUF_DEPTH-word buffer that a host loads/unloads.
// Optional feature macro: DMA_DEV_STALL_EN inserts a one-cycle dev_ack gap
// after every STALL_PERIOD accepted words.
//
// Handshake: in XFER, dev_ack is a pure function of registered state; a word
// moves on every rising edge where dma_ack=1 and idx < num_words. dma_ack with
// idx == num_words is an overrun: the word is dropped and err pulses.
module dma_dev_endpoint #(
  parameter int ADD_LEN      = 16,
  parameter int DATA_LEN     = 16,
  parameter int BUF_DEPTH    = 4,
  parameter int STALL_PERIOD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_start,
  input  logic                cmd_rd_wr,
  input  logic [ADD_LEN-1:0]  cmd_words,
  input  logic [ADD_LEN:0]    cmd_addr,
  input  logic                buf_we,
  input  logic [BUF_DEPTH-1:0] buf_waddr,
  input  logic [DATA_LEN-1:0] buf_wdata,
  input  logic [BUF_DEPTH-1:0] buf_raddr,
  output logic [DATA_LEN-1:0] buf_rdata,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                rqst,
  output logic                rd_wr,
  output logic [ADD_LEN-1:0]  num_words,
  output logic [ADD_LEN:0]    start_addr,
  output logic                dev_ack,
  output logic [DATA_LEN-1:0] dev_in,
  input  logic                dma_ack,
  input  logic [DATA_LEN-1:0] dev_out,
  input  logic                end_flag
);

  localparam int BUF_WORDS = 1 << BUF_DEPTH;
  localparam logic [ADD_LEN-1:0] MAX_WORDS = ADD_LEN'(BUF_WORDS);
  localparam int SCW = $clog2(STALL_PERIOD + 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_PERIOD - 1);
`ifdef DMA_DEV_STALL_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

  state_t               state_q;
  logic                 rd_wr_q;
  logic [ADD_LEN-1:0]   num_words_q;
  logic [ADD_LEN:0]     start_addr_q;
  logic [BUF_DEPTH:0]   idx_q, idx_d;
  logic                 err_q;
  logic [SCW-1:0]       stall_cnt_q;
  logic                 gap_q;
  logic [DATA_LEN-1:0]  buf_rdata_q;
  logic [DATA_LEN-1:0]  mem_q [BUF_WORDS];

  logic in_xfer, idx_lt, accept, rd_accept, cmd_bad, short_xfer;

  assign in_xfer    = (state_q == S_XFER);
  assign idx_lt     = ADD_LEN'(idx_q) < num_words_q;
  assign accept     = in_xfer && dma_ack && idx_lt;
  assign rd_accept  = accept && rd_wr_q;
  assign idx_d      = accept ? idx_q + 1'b1 : idx_q;
  assign cmd_bad    = (cmd_words > MAX_WORDS) || cmd_addr[0];
  // Short is judged after this cycle's word, so a final word arriving with
  // end_flag is not counted as missing.
  assign short_xfer = ADD_LEN'(idx_d) < num_words_q;

  // Control FSM: command acceptance, request pulse, word index and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rd_wr_q      <= 1'b0;
      num_words_q  <= '0;
      start_addr_q <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              rd_wr_q      <= cmd_rd_wr;
              num_words_q  <= cmd_words;
              start_addr_q <= cmd_addr;
              idx_q        <= '0;
              state_q      <= S_REQ;
            end
          end
        end
        S_REQ: state_q <= S_XFER;
        S_XFER: begin
          idx_q <= idx_d;
          if (dma_ack && !idx_lt) err_q <= 1'b1;
          if (end_flag) begin
            state_q <= S_DONE;
            if (short_xfer) err_q <= 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall pacing: counts accepted words and opens a one-cycle dev_ack gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      gap_q       <= 1'b0;
    end else begin
      gap_q <= 1'b0;
      if (state_q == S_REQ) begin
        stall_cnt_q <= '0;
      end else if (accept) begin
        if (stall_cnt_q == STALL_LAST) begin
          stall_cnt_q <= '0;
          gap_q       <= STALL_EN;
        end else begin
          stall_cnt_q <= stall_cnt_q + 1'b1;
        end
      end
    end
  end

  // Buffer storage: host writes only while idle, read transfers fill it.
  always_ff @(posedge clk) begin
    if (buf_we && (state_q == S_IDLE)) begin
      mem_q[buf_waddr] <= buf_wdata;
    end else if (rd_accept) begin
      mem_q[idx_q[BUF_DEPTH-1:0]] <= dev_out;
    end
  end

  // Host read port: one-cycle latency, returns pre-write data on collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) buf_rdata_q <= '0;
    else        buf_rdata_q <= mem_q[buf_raddr];
  end

  assign buf_rdata  = buf_rdata_q;
  assign busy       = (state_q != S_IDLE);
  assign rqst       = (state_q == S_REQ);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign rd_wr      = rd_wr_q;
  assign num_words  = num_words_q;
  assign start_addr = start_addr_q;
  assign dev_ack    = in_xfer && idx_lt && !gap_q;
  // Index MSB set means idx == 2^BUF_DEPTH: nothing left to present.
  assign dev_in     = (in_xfer && !rd_wr_q && !idx_q[BUF_DEPTH])
                      ? mem_q[idx_q[BUF_DEPTH-1:0]] : '0;

endmodule

// File: tb/tb_dma_dev_endpoint.sv
// Self-checking bench for dma_dev_endpoint.
module tb_dma_dev_endpoint;
  localparam int ADD_LEN   = 16;
  localparam int DATA_LEN  = 16;
  localparam int BUF_DEPTH = 4;
`ifdef DMA_DEV_STALL_EN
  localparam int EXP_GAPS = 1;
`else
  localparam int EXP_GAPS = 0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                 cmd_start = 1'b0, cmd_rd_wr = 1'b0;
  logic [ADD_LEN-1:0]   cmd_words = '0;
  logic [ADD_LEN:0]     cmd_addr = '0;
  logic                 buf_we = 1'b0;
  logic [BUF_DEPTH-1:0] buf_waddr = '0, buf_raddr = '0;
  logic [DATA_LEN-1:0]  buf_wdata = '0, dev_out = '0;
  logic                 dma_ack = 1'b0, end_flag = 1'b0;
  logic [DATA_LEN-1:0]  buf_rdata, dev_in;
  logic                 busy, done, err, rqst, rd_wr, dev_ack;
  logic [ADD_LEN-1:0]   num_words;
  logic [ADD_LEN:0]     start_addr;

  dma_dev_endpoint #(.ADD_LEN(ADD_LEN), .DATA_LEN(DATA_LEN), .BUF_DEPTH(BUF_DEPTH), .STALL_PERIOD(4)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_rd_wr(cmd_rd_wr),
    .cmd_words(cmd_words), .cmd_addr(cmd_addr), .buf_we(buf_we), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata), .busy(busy),
    .done(done), .err(err), .rqst(rqst), .rd_wr(rd_wr), .num_words(num_words),
    .start_addr(start_addr), .dev_ack(dev_ack), .dev_in(dev_in), .dma_ack(dma_ack),
    .dev_out(dev_out), .end_flag(end_flag)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_LEN-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host_write(input int a, input logic [DATA_LEN-1:0] d);
    buf_we = 1'b1; buf_waddr = BUF_DEPTH'(a); buf_wdata = d;
    tick();
    buf_we = 1'b0;
  endtask

  task automatic host_read_check(input string tag, input int a);
    logic [DATA_LEN-1:0] e;
    buf_raddr = BUF_DEPTH'(a);
    tick();
    if (exp_q.size() == 0) check({tag, "_qempty"}, 32'(exp_q.size()), 1);
    else begin
      e = exp_q.pop_front();
      check(tag, 32'(buf_rdata), 32'(e));
    end
  endtask

  // Issues a command; leaves the bench at the first XFER negedge when accepted.
  task automatic issue_cmd(input logic rw, input logic [ADD_LEN-1:0] words,
                           input logic [ADD_LEN:0] addr, input logic ok);
    cmd_start = 1'b1; cmd_rd_wr = rw; cmd_words = words; cmd_addr = addr;
    tick();
    cmd_start = 1'b0;
    if (ok) begin
      check("req_rqst", 32'(rqst), 1);
      check("req_busy", 32'(busy), 1);
      check("req_rd_wr", 32'(rd_wr), 32'(rw));
      check("req_num_words", 32'(num_words), 32'(words));
      check("req_start_addr", 32'(start_addr), 32'(addr));
      tick();
      check("xfer_rqst_off", 32'(rqst), 0);
    end else begin
      check("rej_rqst", 32'(rqst), 0);
      check("rej_busy", 32'(busy), 0);
      check("rej_err", 32'(err), 1);
      tick();
      check("rej_err_off", 32'(err), 0);
    end
  endtask

  task automatic finish_xfer(input logic exp_err);
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check("done_pulse", 32'(done), 1);
    check("done_err", 32'(err), 32'(exp_err));
    check("done_busy", 32'(busy), 1);
    tick();
    check("done_off", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_err", 32'(err), 0);
  endtask

  task automatic feed_read_word(input logic [DATA_LEN-1:0] v);
    check("rd_dev_ack", 32'(dev_ack), 1);
    dev_out = v; exp_q.push_back(v); dma_ack = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_LEN-1:0] e, v;
    int accepted, gaps, cyc;

    // Reset state
    #2 reset = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_rqst", 32'(rqst), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_dev_ack", 32'(dev_ack), 0);
    check("rst_dev_in", 32'(dev_in), 0);
    check("rst_num_words", 32'(num_words), 0);
    check("rst_start_addr", 32'(start_addr), 0);
    check("rst_buf_rdata", 32'(buf_rdata), 0);
    reset = 1'b1;
    tick();

    // Write transfer with a 3-cycle dma_ack gap before word 2
    for (int i = 0; i < 4; i++) host_write(i, DATA_LEN'((i + 1) * 'h1111));
    host_write(5, 'h5555);
    for (int i = 0; i < 4; i++) exp_q.push_back(DATA_LEN'((i + 1) * 'h1111));
    issue_cmd(1'b0, 4, 'h200, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        dma_ack = 1'b0;
        for (int g = 0; g < 3; g++) begin
          tick();
          check("wr_gap_dev_in", 32'(dev_in), 32'(exp_q[0]));
          check("wr_gap_dev_ack", 32'(dev_ack), 1);
        end
      end
      check("wr_dev_ack", 32'(dev_ack), 1);
      e = exp_q.pop_front();
      check("wr_dev_in", 32'(dev_in), 32'(e));
      dma_ack = 1'b1;
      tick();
    end
    dma_ack = 1'b0;
    check("wr_dev_ack_end", 32'(dev_ack), 0);
    finish_xfer(1'b0);

    // Read transfer of 3 words
    issue_cmd(1'b1, 3, 'h400, 1'b1);
    feed_read_word('hA5A5);
    feed_read_word('h5A5A);
    feed_read_word('h0F0F);
    dma_ack = 1'b0;
    check("rd_dev_ack_end", 32'(dev_ack), 0);
    check("rd_dev_in_zero", 32'(dev_in), 0);
    finish_xfer(1'b0);
    for (int i = 0; i < 3; i++) host_read_check("rd_buf", i);

    // Overrun: 4th dma_ack on a 3-word read is dropped
    issue_cmd(1'b1, 3, 'h10, 1'b1);
    feed_read_word('h1234);
    feed_read_word('h5678);
    feed_read_word('h9ABC);
    dev_out = 'hDEAD;
    tick();
    dma_ack = 1'b0;
    check("ovr_err", 32'(err), 1);
    tick();
    check("ovr_err_off", 32'(err), 0);
    finish_xfer(1'b0);
    exp_q.push_back('h4444);
    for (int i = 0; i < 4; i++) host_read_check("ovr_buf", i);

    // Short transfer: 1 of 2 words then end_flag
    issue_cmd(1'b1, 2, 'h0, 1'b1);
    feed_read_word('h7777);
    dma_ack = 1'b0;
    exp_q.delete();
    finish_xfer(1'b1);

    // Full-depth count accepted; end_flag with no words is short
    issue_cmd(1'b1, 16, 'h0, 1'b1);
    check("full_dev_ack", 32'(dev_ack), 1);
    finish_xfer(1'b1);

    // Zero count; host write while busy is ignored
    issue_cmd(1'b0, 0, 'h20, 1'b1);
    check("zero_dev_ack", 32'(dev_ack), 0);
    buf_we = 1'b1; buf_waddr = 5; buf_wdata = 'hBEEF;
    tick();
    buf_we = 1'b0;
    check("zero_dev_ack2", 32'(dev_ack), 0);
    finish_xfer(1'b0);
    exp_q.push_back('h5555);
    host_read_check("busy_we_ignored", 5);

    // Rejected commands
    issue_cmd(1'b0, 17, 'h0, 1'b0);
    issue_cmd(1'b0, 4, 'h201, 1'b0);

    // Reset mid-transfer, then restart from buf[0]
    for (int i = 0; i < 4; i++) host_write(i, DATA_LEN'((i + 1) * 'h1111));
    issue_cmd(1'b0, 4, 'h200, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check("mid_dev_in", 32'(dev_in), 32'((i + 1) * 'h1111));
      dma_ack = 1'b1;
      tick();
    end
    dma_ack = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_rqst", 32'(rqst), 0);
    check("mid_rst_dev_ack", 32'(dev_ack), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    tick();
    reset = 1'b1;
    tick();
    issue_cmd(1'b0, 2, 'h200, 1'b1);
    check("restart_dev_in0", 32'(dev_in), 'h1111);
    dma_ack = 1'b1;
    tick();
    check("restart_dev_in1", 32'(dev_in), 'h2222);
    tick();
    dma_ack = 1'b0;
    check("restart_dev_ack_end", 32'(dev_ack), 0);
    finish_xfer(1'b0);

    // Same-cycle host write and read returns old data
    buf_raddr = 0; buf_we = 1'b1; buf_waddr = 0; buf_wdata = 'hCAFE;
    tick();
    buf_we = 1'b0;
    check("rw_same_old", 32'(buf_rdata), 'h1111);
    tick();
    check("rw_same_new", 32'(buf_rdata), 'hCAFE);

    // 8-word read following dev_ack; counts dev_ack gaps
    issue_cmd(1'b1, 8, 'h40, 1'b1);
    accepted = 0; gaps = 0; cyc = 0;
    while (accepted < 8 && cyc < 40) begin
      if (dev_ack) begin
        v = DATA_LEN'($urandom_range(0, 65535));
        dev_out = v; exp_q.push_back(v); dma_ack = 1'b1;
        accepted++;
      end else begin
        dma_ack = 1'b0;
        gaps++;
      end
      tick();
      cyc++;
    end
    dma_ack = 1'b0;
    check("stall_words", accepted, 8);
    check("stall_gaps", gaps, EXP_GAPS);
    check("stall_dev_ack_end", 32'(dev_ack), 0);
    finish_xfer(1'b0);
    for (int i = 0; i < 8; i++) host_read_check("stall_buf", i);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dma_dev_endpoint.md
Name: dma_dev_endpoint

Overview:
- Device-side endpoint of the DMA device handshake. It issues transfer requests to the DMA controller and supplies or consumes the data words for each transfer.
- It holds a local word buffer that a host peripheral loads and unloads through a simple register-file port.
- It sits between a peripheral core and the DMA controller's device interface.
- rd_wr=1 is a memory-to-device (read) transfer; rd_wr=0 is a device-to-memory (write) transfer.

Parameters:
- ADD_LEN, 16, word-address width; start_addr is ADD_LEN+1 bits wide (byte address).
- DATA_LEN, 16, data word width.
- BUF_DEPTH, 4, local buffer holds 2^BUF_DEPTH words.
- STALL_PERIOD, 4, accepted words between forced dev_ack gaps (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cmd_start  in  1  one-cycle transfer command.
- cmd_rd_wr  in  1  transfer direction for the command.
- cmd_words  in  ADD_LEN  word count for the command.
- cmd_addr  in  ADD_LEN+1  byte start address; bit 0 must be 0.
- buf_we  in  1  host buffer write strobe.
- buf_waddr  in  BUF_DEPTH  host buffer write index.
- buf_wdata  in  DATA_LEN  host buffer write data.
- buf_raddr  in  BUF_DEPTH  host buffer read index.
- buf_rdata  out  DATA_LEN  host buffer read data, registered.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse on rejected command, overrun or short transfer.
- rqst  out  1  transfer request to the DMA controller.
- rd_wr  out  1  direction to the DMA controller.
- num_words  out  ADD_LEN  word count to the DMA controller.
- start_addr  out  ADD_LEN+1  byte start address to the DMA controller.
- dev_ack  out  1  endpoint ready (read) / dev_in valid (write).
- dev_in  out  DATA_LEN  write data to the DMA controller.
- dma_ack  in  1  word transferred this cycle.
- dev_out  in  DATA_LEN  read data from the DMA controller, valid while dma_ack=1.
- end_flag  in  1  transfer-complete pulse from the DMA controller.

Behaviour:
- Reset (reset=0): every output is 0, FSM goes to IDLE, word index idx is 0. Buffer contents are not reset. Reset takes effect immediately, including mid-transfer.
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE:
  - cmd_start is rejected (stay in IDLE, err=1 for one cycle) if cmd_words > 2^BUF_DEPTH or cmd_addr[0]=1.
  - Otherwise, on cmd_start: latch cmd_rd_wr into rd_wr, cmd_words into num_words, cmd_addr into start_addr; clear idx; go to REQ.
- REQ: rqst=1 for exactly one cycle, then go to XFER.
- rd_wr, num_words and start_addr stay stable from REQ until the DONE cycle ends.
- busy=1 in REQ, XFER and DONE.
- XFER:
  - dev_ack = (idx < num_words). dev_ack depends only on registered state, not on dma_ack.
  - Read (rd_wr=1): on each rising edge with dma_ack=1 and idx<num_words, write dev_out into buf[idx] and increment idx.
  - Read, dma_ack=1 with idx==num_words: drop the word, err=1 for one cycle, idx holds.
  - Write (rd_wr=0): dev_in = buf[idx] combinationally. On each rising edge with dma_ack=1, increment idx. The next word is presented in the following cycle, so back-to-back dma_ack advances one word per cycle.
  - Write, dma_ack=0: dev_in and idx hold.
  - Outside XFER-write, dev_in = 0.
  - end_flag=1 in XFER: go to DONE. If idx < num_words, also pulse err=1 (short transfer).
  - num_words=0: dev_ack stays 0; wait for end_flag.
- DONE: done=1 for one cycle, then go to IDLE.
- cmd_start outside IDLE is ignored.
- end_flag outside XFER is ignored.
- Host buffer port:
  - buf_we is ignored while busy=1.
  - When busy=0, buf_we writes on the clock edge.
  - buf_rdata = buf[buf_raddr] with one-cycle latency; reads are allowed at any time.
  - A same-cycle host write and read to the same index returns the old data.
- idx is BUF_DEPTH+1 bits wide; it never wraps because its maximum value is 2^BUF_DEPTH.

Optional Feature:
- Macro: DMA_DEV_STALL_EN.
- Defined: after every STALL_PERIOD words accepted in XFER, dev_ack is forced to 0 for one cycle. This exercises the controller's wait paths. A dma_ack arriving during the gap is handled exactly as in the normal case.
- Undefined: dev_ack = (idx < num_words) with no gaps.

Test Plan:
- Write: load buf[0..3]=0x1111/0x2222/0x3333/0x4444; cmd_start, rd_wr=0, words=4, addr=0x0200 -> one-cycle rqst, num_words=4, start_addr=0x0200; dev_in presents 0x1111..0x4444 on successive dma_ack cycles; end_flag -> done pulse, err stays 0.
- Read: words=3; model drives dev_out=0xA5A5, 0x5A5A, 0x0F0F with dma_ack, then end_flag -> buf_raddr 0,1,2 returns those values one cycle later; dev_ack drops after the third word.
- Zero count: words=0 -> rqst pulse, dev_ack stays 0; end_flag -> done=1, err=0.
- Rejects: words=17 (BUF_DEPTH=4) -> no rqst, err pulse; addr=0x0201 -> no rqst, err pulse; overrun (4th dma_ack on a words=3 read) -> err pulse, buf[3] unchanged.
- Reset mid-transfer: reset=0 after 2 of 4 write words -> rqst, dev_ack, busy, done immediately 0; a new command then restarts at buf[0].
- Gaps: dma_ack low for 3 cycles mid-write -> dev_in and idx hold. With DMA_DEV_STALL_EN and STALL_PERIOD=4 on an 8-word read: dev_ack=0 for one cycle after word 4, transfer completes, err=0.
